pipe_stage_buffer: RTL
======================

Name: pipe_stage_buffer

Overview:
Parametrised, generic replacement for the fixed per-stage pipeline registers (decode/execute/memory-access/write-back) between adjacent pipeline stages. Carries an opaque packed payload (the stage struct, cast to a bit vector) with a valid/ready handshake on both sides, an optional skid entry that registers upstream ready, a synchronous flush, and a saturating stall-cycle counter for performance monitoring. The existing stage structs remain the payload types.

Parameters:
DATA_WIDTH, 64, payload width in bits (set to $bits of the stage struct)
SKID_EN, 1, 1 = two-entry (main + skid) buffer with registered in_ready; 0 = single entry with combinational in_ready
CNT_WIDTH, 16, width of stall counter
RESET_PAYLOAD, '0, payload value held in entries at reset and after flush

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  upstream payload valid
in_ready  out  1  buffer can accept this cycle
in_data  in  DATA_WIDTH  upstream payload
out_valid  out  1  main entry holds valid payload
out_ready  in  1  downstream consumes this cycle
out_data  out  DATA_WIDTH  main entry payload
flush  in  1  discard all held and incoming payloads (branch mispredict / halt)
stall_cnt  out  CNT_WIDTH  cycles with out_valid=1 and out_ready=0, saturating
stall_cnt_clr  in  1  synchronous clear of stall_cnt

Behaviour:
- Reset (rst_n=0, async): out_valid=0, skid valid=0, both entries=RESET_PAYLOAD, stall_cnt=0; in_ready=1 during and after reset.
- Transfer: in-fire = in_valid & in_ready; out-fire = out_valid & out_ready. All state updates on rising clk.
- Latency: in-fire at cycle N -> out_valid=1 with that data at N+1 (if main empty or draining). No combinational in_data->out_data path.
- SKID_EN=1:
  - in_ready = !skid_valid (registered; no path from out_ready).
  - States: EMPTY (main 0, skid 0), ONE (main 1, skid 0), FULL (main 1, skid 1).
  - EMPTY: in-fire -> ONE, main<=in_data.
  - ONE: in-fire & out-fire -> ONE, main<=in_data; in-fire & !out-fire -> FULL, skid<=in_data; out-fire only -> EMPTY.
  - FULL: in_ready=0; out-fire -> ONE, main<=skid; else hold.
  - Order preserved: skid data always leaves after main.
- SKID_EN=0: single entry; in_ready = !out_valid | out_ready (combinational). States EMPTY/ONE only.
- Flush: highest priority. Cycle after flush=1: out_valid=0, skid valid=0, entries=RESET_PAYLOAD, regardless of in_valid/out_ready that cycle. An in_valid beat presented with flush is dropped (in_ready may read 1; beat is not stored). Out-fire coincident with flush is still a valid consumption downstream.
- Stall counter: increments when out_valid & !out_ready & !flush; saturates at all-ones (no wrap). stall_cnt_clr has priority over increment -> 0 next cycle. Flush does not clear the counter.
- Payload in invalid entries is don't-care to consumers but must equal RESET_PAYLOAD after reset/flush (keeps waveforms and equivalence checks deterministic).
- Reset asserted mid-transfer: all entries invalid immediately (async), no partial payload emitted.

Decomposition:
- PipelineTypes package: keep stage structs; add localparam widths per stage (e.g. DECODE_REG_W = $bits(DecodeStagePipeReg)) and typedef PipeStall for CNT_WIDTH-sized counters.
- One sub-module natural: sat_counter (CNT_WIDTH, inc, clr, value), reusable by other perf counters. Entry/skid logic stays in pipe_stage_buffer.

Test Plan:
- Streaming: SKID_EN=1, out_ready=1, in_valid=1 for 8 beats 0x01..0x08 -> out_data 0x01..0x08 on consecutive cycles, one-cycle latency, in_ready=1 throughout, stall_cnt=0.
- Backpressure: push 0xA1, 0xA2 with out_ready=0 -> FULL, in_ready=0 next cycle, 0xA3 held upstream; release out_ready -> outputs 0xA1, 0xA2, 0xA3 in order, no loss/duplication; stall_cnt equals cycles held.
- Flush in FULL with in_valid=1 (0xB3) -> next cycle out_valid=0, in_ready=1, out_data=RESET_PAYLOAD, 0xB3 never appears.
- SKID_EN=0: out_valid=1, out_ready=0 -> in_ready=0 same cycle; out_ready=1 with in_valid=1 -> replacement next cycle, full throughput.
- Saturation: CNT_WIDTH=4, hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt stops at 15; assert stall_cnt_clr with stall continuing -> 0 then increments.
- Async reset mid-FULL: drop rst_n between edges -> out_valid=0, in_ready=1 immediately, stall_cnt=0.

Source files
------------

// File: rtl/pipe_stage_buffer_pkg.sv
// Shared pipeline types: stage payload structs, their widths, the buffer
// occupancy states and the stall-counter type.
package pipe_stage_buffer_pkg;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } BufState;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } DecodeStagePipeReg;

    typedef struct packed {
        logic [31:0] aluResult;
        logic [31:0] storeData;
        logic [4:0]  rd;
        logic        regWrite;
        logic        memRead;
        logic        memWrite;
    } ExecuteStagePipeReg;

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        regWrite;
        logic        memToReg;
    } MemoryStagePipeReg;

    typedef struct packed {
        logic [31:0] writeData;
        logic [4:0]  rd;
        logic        regWrite;
    } WriteBackStagePipeReg;

    localparam int DECODE_REG_W    = $bits(DecodeStagePipeReg);
    localparam int EXECUTE_REG_W   = $bits(ExecuteStagePipeReg);
    localparam int MEMORY_REG_W    = $bits(MemoryStagePipeReg);
    localparam int WRITEBACK_REG_W = $bits(WriteBackStagePipeReg);

    localparam int PIPE_STALL_W = 16;
    typedef logic [PIPE_STALL_W-1:0] PipeStall;

endpackage

// File: rtl/pipe_stage_buffer_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module pipe_stage_buffer_sat_counter #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inc_i,
    input  logic                 clr_i,
    output logic [CNT_WIDTH-1:0] value_o
);

    logic [CNT_WIDTH-1:0] count_q;
    logic [CNT_WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != '1)) begin
            count_d = count_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign value_o = count_q;

endmodule

// File: rtl/pipe_stage_buffer.sv
// Generic valid/ready pipeline register between two stages, with optional
// skid entry (registered in_ready), flush and a stall-cycle counter.
module pipe_stage_buffer
    import pipe_stage_buffer_pkg::*;
#(
    parameter int                    DATA_WIDTH    = 64,
    parameter bit                    SKID_EN       = 1'b1,
    parameter int                    CNT_WIDTH     = 16,
    parameter logic [DATA_WIDTH-1:0] RESET_PAYLOAD = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  flush,
    output logic [CNT_WIDTH-1:0]  stall_cnt,
    input  logic                  stall_cnt_clr
);

    BufState               state_q, state_d;
    logic [DATA_WIDTH-1:0] mainData_q, mainData_d;
    logic [DATA_WIDTH-1:0] skidData_q, skidData_d;
    logic                  skidValid;
    logic                  inFire;
    logic                  outFire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BUF_EMPTY;
            mainData_q <= RESET_PAYLOAD;
            skidData_q <= RESET_PAYLOAD;
        end else begin
            state_q    <= state_d;
            mainData_q <= mainData_d;
            skidData_q <= skidData_d;
        end
    end

    // Without a skid entry an accept-without-drain in ONE cannot occur,
    // so FULL is only ever reachable when SKID_EN is set.
    always_comb begin
        inFire     = in_valid & in_ready;
        outFire    = out_valid & out_ready;
        state_d    = state_q;
        mainData_d = mainData_q;
        skidData_d = skidData_q;
        if (flush) begin
            state_d    = BUF_EMPTY;
            mainData_d = RESET_PAYLOAD;
            skidData_d = RESET_PAYLOAD;
        end else begin
            unique case (state_q)
                BUF_EMPTY: begin
                    if (inFire) begin
                        state_d    = BUF_ONE;
                        mainData_d = in_data;
                    end
                end
                BUF_ONE: begin
                    if (inFire && outFire) begin
                        mainData_d = in_data;
                    end else if (inFire) begin
                        state_d    = SKID_EN ? BUF_FULL : BUF_ONE;
                        skidData_d = in_data;
                    end else if (outFire) begin
                        state_d = BUF_EMPTY;
                    end
                end
                BUF_FULL: begin
                    if (outFire) begin
                        state_d    = BUF_ONE;
                        mainData_d = skidData_q;
                        skidData_d = RESET_PAYLOAD;
                    end
                end
                default: begin
                    state_d = BUF_EMPTY;
                end
            endcase
        end
    end

    always_comb begin
        out_valid = (state_q != BUF_EMPTY);
        skidValid = (state_q == BUF_FULL);
        out_data  = mainData_q;
        if (SKID_EN) begin
            in_ready = !skidValid;
        end else begin
            in_ready = !out_valid | out_ready;
        end
    end

    pipe_stage_buffer_sat_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_stallCounter (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (out_valid & ~out_ready & ~flush),
        .clr_i   (stall_cnt_clr),
        .value_o (stall_cnt)
    );

endmodule
